// File: rtl/fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_param                                                       |
// | Brief   : Single-clock FIFO, any depth >= 2, with occupancy count, flush,  |
// |           read-valid strobe and registered request status strobes.         |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             wr_en,
    input  logic [FIFO_WIDTH-1:0]            data_in,
    input  logic                             rd_en,
    output logic [FIFO_WIDTH-1:0]            data_out,
    output logic                             rd_valid,
    output logic                             wr_ack,
    output logic                             overflow,
    output logic                             underflow,
    output logic                             full,
    output logic                             empty,
    output logic                             almostfull,
    output logic                             almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_AF   = c_CNT_W'(AF_LEVEL);
    localparam logic [c_CNT_W-1:0] c_CNT_AE   = c_CNT_W'(AE_LEVEL);

    generate
        if (FIFO_WIDTH < 1) begin : g_bad_width
            $error("fifo_param: FIFO_WIDTH must be >= 1");
        end
        if (FIFO_DEPTH < 2) begin : g_bad_depth
            $error("fifo_param: FIFO_DEPTH must be >= 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH - 1) begin : g_bad_af
            $error("fifo_param: AF_LEVEL must be within 1..FIFO_DEPTH-1");
        end
        if (AE_LEVEL < 1 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
            $error("fifo_param: AE_LEVEL must be within 1..FIFO_DEPTH-1");
        end
    endgenerate

    logic [FIFO_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [FIFO_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_PTR_W-1:0]    w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]    w_rd_ptr_nxt;

    // Status flags decode straight from the count register.
    assign w_full   = (r_count == c_CNT_FULL);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en & ~w_full  & ~flush;
    assign w_rd_acc = rd_en & ~w_empty & ~flush;

    // Explicit wrap so non-power-of-two depths work.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en & w_full  & ~flush;
            r_underflow <= rd_en & w_empty & ~flush;
            r_rd_valid  <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= w_rd_ptr_nxt;
                end
                case ({w_wr_acc, w_rd_acc})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign data_out    = r_data_out;
    assign rd_valid    = r_rd_valid;
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= c_CNT_AF) & ~w_full;
    assign almostempty = (r_count <= c_CNT_AE) & ~w_empty;
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fifo_param                                                    |
// | Brief   : Self-checking bench for fifo_param (depth 8 table, depth 6 random)|
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fifo_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Depth-8 instance
    logic        d8_flush, d8_wr, d8_rd;
    logic [15:0] d8_din, d8_dout;
    logic        d8_rdv, d8_ack, d8_ovf, d8_udf, d8_full, d8_empty, d8_af, d8_ae;
    logic [3:0]  d8_count;

    // Depth-6 instance
    logic        d6_flush, d6_wr, d6_rd;
    logic [15:0] d6_din, d6_dout;
    logic        d6_rdv, d6_ack, d6_ovf, d6_udf, d6_full, d6_empty, d6_af, d6_ae;
    logic [2:0]  d6_count;

    fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .flush(d8_flush), .wr_en(d8_wr), .data_in(d8_din),
        .rd_en(d8_rd), .data_out(d8_dout), .rd_valid(d8_rdv), .wr_ack(d8_ack),
        .overflow(d8_ovf), .underflow(d8_udf), .full(d8_full), .empty(d8_empty),
        .almostfull(d8_af), .almostempty(d8_ae), .count(d8_count)
    );

    fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) dut6 (
        .clk(clk), .rst(rst), .flush(d6_flush), .wr_en(d6_wr), .data_in(d6_din),
        .rd_en(d6_rd), .data_out(d6_dout), .rd_valid(d6_rdv), .wr_ack(d6_ack),
        .overflow(d6_ovf), .underflow(d6_udf), .full(d6_full), .empty(d6_empty),
        .almostfull(d6_af), .almostempty(d6_ae), .count(d6_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        wr, rd;
        logic [15:0] din;
        int          cnt;
        logic        ack, ovf, udf, rdv;
        logic [15:0] dout;
        logic        full, empty, af, ae;
    } vec_t;

    vec_t vecs[$];

    // Flags for depth 8 with default levels: AF at 7, AE at 1.
    function automatic void mk(input logic wr, input logic rd, input logic [15:0] din,
                               input int cnt, input logic ack, input logic ovf,
                               input logic udf, input logic rdv, input logic [15:0] dout);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
        v.ack = ack; v.ovf = ovf; v.udf = udf; v.rdv = rdv; v.dout = dout;
        v.full  = (cnt == 8);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 7) && (cnt != 8);
        v.ae    = (cnt <= 1) && (cnt != 0);
        vecs.push_back(v);
    endfunction

    task automatic chk_d8_reset(input string tag);
        chk({tag, " dout"},  32'(d8_dout), 32'h0);
        chk({tag, " rdv"},   32'(d8_rdv), 32'h0);
        chk({tag, " ack"},   32'(d8_ack), 32'h0);
        chk({tag, " ovf"},   32'(d8_ovf), 32'h0);
        chk({tag, " udf"},   32'(d8_udf), 32'h0);
        chk({tag, " full"},  32'(d8_full), 32'h0);
        chk({tag, " empty"}, 32'(d8_empty), 32'h1);
        chk({tag, " af"},    32'(d8_af), 32'h0);
        chk({tag, " ae"},    32'(d8_ae), 32'h0);
        chk({tag, " count"}, 32'(d8_count), 32'h0);
    endtask

    initial begin
        logic [15:0] q6[$];
        logic [15:0] exp_d6;
        logic [15:0] held;
        int          nwr, nrd, sz, pw, pr;
        logic        wa, ra, ov, ud;

        rst = 1'b1;
        d8_flush = 0; d8_wr = 0; d8_rd = 0; d8_din = 0;
        d6_flush = 0; d6_wr = 0; d6_rd = 0; d6_din = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_d8_reset("reset");
        chk("reset d6 empty", 32'(d6_empty), 32'h1);
        chk("reset d6 count", 32'(d6_count), 32'h0);
        rst = 1'b0;

        // Fill, overflow, drain, underflow, simultaneous R/W at empty and full
        for (int i = 1; i <= 8; i++) mk(1, 0, 16'(i), i, 1, 0, 0, 0, 16'h0);
        mk(1, 0, 16'h0009, 8, 0, 1, 0, 0, 16'h0);
        for (int k = 1; k <= 8; k++) mk(0, 1, 16'h0, 8 - k, 0, 0, 0, 1, 16'(k));
        mk(0, 1, 16'h0, 0, 0, 0, 1, 0, 16'h0008);
        mk(1, 1, 16'hAAAA, 1, 1, 0, 1, 0, 16'h0008);
        mk(1, 1, 16'hBBBB, 1, 1, 0, 0, 1, 16'hAAAA);
        for (int j = 1; j <= 7; j++) mk(1, 0, 16'h0C00 + 16'(j), 1 + j, 1, 0, 0, 0, 16'hAAAA);
        mk(1, 1, 16'hDDDD, 7, 0, 1, 0, 1, 16'hBBBB);

        for (int i = 0; i < vecs.size(); i++) begin
            d8_wr = vecs[i].wr; d8_rd = vecs[i].rd; d8_din = vecs[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i), 32'(d8_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d ack", i),   32'(d8_ack),   32'(vecs[i].ack));
            chk($sformatf("v%0d ovf", i),   32'(d8_ovf),   32'(vecs[i].ovf));
            chk($sformatf("v%0d udf", i),   32'(d8_udf),   32'(vecs[i].udf));
            chk($sformatf("v%0d rdv", i),   32'(d8_rdv),   32'(vecs[i].rdv));
            chk($sformatf("v%0d dout", i),  32'(d8_dout),  32'(vecs[i].dout));
            chk($sformatf("v%0d full", i),  32'(d8_full),  32'(vecs[i].full));
            chk($sformatf("v%0d empty", i), 32'(d8_empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d af", i),    32'(d8_af),    32'(vecs[i].af));
            chk($sformatf("v%0d ae", i),    32'(d8_ae),    32'(vecs[i].ae));
        end
        d8_wr = 0; d8_rd = 0;

        // Random traffic on the depth-6 FIFO against a queue model
        exp_d6 = 16'h0; nwr = 0; nrd = 0;
        for (int c = 0; c < 240; c++) begin
            pw = ((c / 20) % 2 == 0) ? 75 : 30;
            pr = 100 - pw;
            d6_wr  = ($urandom_range(0, 99) < pw);
            d6_rd  = ($urandom_range(0, 99) < pr);
            d6_din = 16'($urandom);
            sz = q6.size();
            wa = d6_wr && (sz < 6);
            ra = d6_rd && (sz > 0);
            ov = d6_wr && (sz == 6);
            ud = d6_rd && (sz == 0);
            if (ra) begin exp_d6 = q6.pop_front(); nrd++; end
            if (wa) begin q6.push_back(d6_din); nwr++; end
            @(posedge clk);
            #1;
            sz = q6.size();
            chk($sformatf("r%0d count", c), 32'(d6_count), 32'(nwr - nrd));
            chk($sformatf("r%0d dout", c),  32'(d6_dout),  32'(exp_d6));
            chk($sformatf("r%0d rdv", c),   32'(d6_rdv),   32'(ra));
            chk($sformatf("r%0d ack", c),   32'(d6_ack),   32'(wa));
            chk($sformatf("r%0d ovf", c),   32'(d6_ovf),   32'(ov));
            chk($sformatf("r%0d udf", c),   32'(d6_udf),   32'(ud));
            chk($sformatf("r%0d full", c),  32'(d6_full),  32'(sz == 6));
            chk($sformatf("r%0d empty", c), 32'(d6_empty), 32'(sz == 0));
            chk($sformatf("r%0d af", c),    32'(d6_af),    32'(sz == 5));
            chk($sformatf("r%0d ae", c),    32'(d6_ae),    32'(sz == 1));
        end
        d6_wr = 0; d6_rd = 0;

        // Flush alone, then flush competing with write and read
        held = 16'hBBBB;
        d8_flush = 1;
        @(posedge clk);
        #1;
        chk("flush0 count", 32'(d8_count), 32'h0);
        chk("flush0 empty", 32'(d8_empty), 32'h1);
        d8_flush = 0;
        d8_wr = 1;
        for (int i = 1; i <= 5; i++) begin
            d8_din = 16'h5000 + 16'(i);
            @(posedge clk);
            #1;
        end
        chk("load5 count", 32'(d8_count), 32'h5);
        d8_flush = 1; d8_rd = 1; d8_din = 16'hEEEE;
        @(posedge clk);
        #1;
        chk("flush count", 32'(d8_count), 32'h0);
        chk("flush empty", 32'(d8_empty), 32'h1);
        chk("flush ack",   32'(d8_ack),   32'h0);
        chk("flush rdv",   32'(d8_rdv),   32'h0);
        chk("flush ovf",   32'(d8_ovf),   32'h0);
        chk("flush udf",   32'(d8_udf),   32'h0);
        chk("flush dout",  32'(d8_dout),  32'(held));
        d8_flush = 0; d8_rd = 0;

        // Asynchronous reset in the middle of a burst
        for (int i = 1; i <= 3; i++) begin
            d8_din = 16'h6000 + 16'(i);
            @(posedge clk);
            #1;
        end
        d8_rd = 1; d8_din = 16'h6004;
        @(posedge clk);
        #1;
        chk("burst dout", 32'(d8_dout), 32'h6001);
        chk("burst rdv",  32'(d8_rdv),  32'h1);
        chk("burst cnt",  32'(d8_count), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        chk_d8_reset("async");
        @(posedge clk);
        #1;
        chk("inreset count", 32'(d8_count), 32'h0);
        rst = 1'b0;
        d8_wr = 1; d8_rd = 0; d8_din = 16'h7777;
        @(posedge clk);
        #1;
        chk("post ack",   32'(d8_ack),   32'h1);
        chk("post count", 32'(d8_count), 32'h1);
        d8_wr = 0; d8_rd = 1;
        @(posedge clk);
        #1;
        chk("post dout",  32'(d8_dout),  32'h7777);
        chk("post rdv",   32'(d8_rdv),   32'h1);
        chk("post empty", 32'(d8_empty), 32'h1);
        d8_rd = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
